// File: rtl/serial_tx_scheduler.sv
// serial_tx_scheduler: comma training preamble, then round-robin byte
// arbitration of NUM_CH requesters onto an MSB-first serial stream.
module serial_tx_scheduler #(
  parameter int         NUM_CH      = 2,
  parameter int         TRAIN_BYTES = 4,
  parameter logic [7:0] IDLE_BYTE   = 8'hBC
) (
  input  logic                  clk_32f,
  input  logic                  reset,
  input  logic [NUM_CH-1:0]     in_valid,
  input  logic [8*NUM_CH-1:0]   in_data,
  output logic [NUM_CH-1:0]     in_ready,
  output logic                  Data_out,
  output logic                  byte_start,
  output logic                  grant_valid,
  output logic [1:0]            grant_ch,
  output logic                  trained
);

  localparam int TC_W = $clog2(TRAIN_BYTES + 1);

  typedef enum logic {
    TRAIN,
    RUN
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [TC_W-1:0]   train_cnt_q, train_cnt_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [NUM_CH-1:0] hold_valid_q, hold_valid_d;
  logic [7:0]        hold_data_q [NUM_CH];
  logic [7:0]        hold_data_d [NUM_CH];
  logic              data_out_q, data_out_d;
  logic              byte_start_q, byte_start_d;
  logic              grant_valid_q, grant_valid_d;
  logic [1:0]        grant_ch_q, grant_ch_d;
  logic              trained_q, trained_d;

  logic       load;
  logic       found;
  logic [1:0] pick;
  logic [7:0] pick_byte;
  logic [2:0] idx;
  logic [2:0] nxt;
  logic [1:0] rr_next;
  logic [7:0] sel_byte;

  assign load        = (bit_cnt_q == 3'd7);
  assign in_ready    = ~hold_valid_q;
  assign Data_out    = data_out_q;
  assign byte_start  = byte_start_q;
  assign grant_valid = grant_valid_q;
  assign grant_ch    = grant_ch_q;
  assign trained     = trained_q;

  // first pending channel at or after rr_ptr, wrapping mod NUM_CH
  always_comb begin
    found     = 1'b0;
    pick      = 2'd0;
    pick_byte = IDLE_BYTE;
    idx       = 3'd0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = 3'(rr_ptr_q) + 3'(k);
      if (idx >= 3'(NUM_CH)) idx = idx - 3'(NUM_CH);
      for (int j = 0; j < NUM_CH; j++) begin
        if (!found && idx == 3'(j) && hold_valid_q[j]) begin
          found     = 1'b1;
          pick      = 2'(j);
          pick_byte = hold_data_q[j];
        end
      end
    end
  end

  assign nxt     = 3'(pick) + 3'd1;
  assign rr_next = (nxt == 3'(NUM_CH)) ? 2'd0 : nxt[1:0];

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q + 3'd1;
    shift_d       = shift_q;
    train_cnt_d   = train_cnt_q;
    rr_ptr_d      = rr_ptr_q;
    hold_valid_d  = hold_valid_q;
    hold_data_d   = hold_data_q;
    data_out_d    = shift_q[3'd6 - bit_cnt_q];
    byte_start_d  = 1'b0;
    grant_valid_d = 1'b0;
    grant_ch_d    = grant_ch_q;
    trained_d     = trained_q;
    sel_byte      = IDLE_BYTE;

    for (int i = 0; i < NUM_CH; i++) begin
      if (in_valid[i] && !hold_valid_q[i]) begin
        hold_valid_d[i] = 1'b1;
        hold_data_d[i]  = in_data[8*i +: 8];
      end
    end

    if (load) begin
      bit_cnt_d    = 3'd0;
      byte_start_d = 1'b1;
      unique case (state_q)
        TRAIN: begin
          train_cnt_d = train_cnt_q + TC_W'(1);
          if (train_cnt_q == TC_W'(TRAIN_BYTES - 1)) state_d = RUN;
        end
        RUN: begin
          trained_d = 1'b1;
          if (found) begin
            sel_byte      = pick_byte;
            grant_valid_d = 1'b1;
            grant_ch_d    = pick;
            rr_ptr_d      = rr_next;
            for (int j = 0; j < NUM_CH; j++) begin
              if (pick == 2'(j)) hold_valid_d[j] = 1'b0;
            end
          end
        end
        default: ;
      endcase
      data_out_d = sel_byte[7];
      shift_d    = sel_byte;
    end
  end

  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      state_q       <= TRAIN;
      bit_cnt_q     <= 3'd7;
      shift_q       <= 8'h00;
      train_cnt_q   <= '0;
      rr_ptr_q      <= 2'd0;
      hold_valid_q  <= '0;
      hold_data_q   <= '{default: 8'h00};
      data_out_q    <= 1'b0;
      byte_start_q  <= 1'b0;
      grant_valid_q <= 1'b0;
      grant_ch_q    <= 2'd0;
      trained_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      train_cnt_q   <= train_cnt_d;
      rr_ptr_q      <= rr_ptr_d;
      hold_valid_q  <= hold_valid_d;
      hold_data_q   <= hold_data_d;
      data_out_q    <= data_out_d;
      byte_start_q  <= byte_start_d;
      grant_valid_q <= grant_valid_d;
      grant_ch_q    <= grant_ch_d;
      trained_q     <= trained_d;
    end
  end

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// tb_serial_tx_scheduler: random and directed traffic against a
// slot-level reference model of the training/round-robin link.
module tb_serial_tx_scheduler;

  localparam int         NUM_CH = 2;
  localparam int         TRAIN  = 4;
  localparam logic [7:0] IDLE   = 8'hBC;
  localparam int         OW     = 6 + NUM_CH;

  logic                clk_32f = 1'b0;
  logic                reset = 1'b0;
  logic [NUM_CH-1:0]   in_valid = '0;
  logic [8*NUM_CH-1:0] in_data = '0;
  logic [NUM_CH-1:0]   in_ready;
  logic                Data_out;
  logic                byte_start;
  logic                grant_valid;
  logic [1:0]          grant_ch;
  logic                trained;

  serial_tx_scheduler #(
    .NUM_CH(NUM_CH),
    .TRAIN_BYTES(TRAIN),
    .IDLE_BYTE(IDLE)
  ) dut (
    .clk_32f(clk_32f),
    .reset(reset),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .Data_out(Data_out),
    .byte_start(byte_start),
    .grant_valid(grant_valid),
    .grant_ch(grant_ch),
    .trained(trained)
  );

  always #5 clk_32f = ~clk_32f;

  int vecs = 0;
  int errs = 0;

  // reference model: n = edges since reset release, slot = n/8
  int                n = 0;
  int                m_rr = 0;
  logic [NUM_CH-1:0] m_hold = '0;
  logic [7:0]        m_data [NUM_CH];
  logic [7:0]        cur = 8'h00;
  logic              e_do = 1'b0;
  logic              e_bs = 1'b0;
  logic              e_gv = 1'b0;
  logic              e_tr = 1'b0;
  logic              m_rst = 1'b1;
  logic [1:0]        e_gc = 2'd0;

  logic [NUM_CH-1:0] off_v = '0;
  logic [7:0]        off_d [NUM_CH];
  logic [7:0]        q [NUM_CH][$];
  bit                gate = 1'b0;

  function automatic logic [OW-1:0] got();
    logic [1:0] gc;
    gc = (e_gv || m_rst) ? grant_ch : 2'b00;
    return {Data_out, byte_start, grant_valid, trained, gc, in_ready};
  endfunction

  function automatic logic [OW-1:0] expv();
    logic [1:0] gc;
    gc = (e_gv || m_rst) ? e_gc : 2'b00;
    return {e_do, e_bs, e_gv, e_tr, gc, ~m_hold};
  endfunction

  task automatic drive();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (!off_v[ch] && q[ch].size() > 0 &&
          (!gate || $urandom_range(0, 2) == 0)) begin
        off_v[ch] = 1'b1;
        off_d[ch] = q[ch].pop_front();
      end
    end
    in_valid = off_v;
    for (int ch = 0; ch < NUM_CH; ch++)
      in_data[8*ch +: 8] = off_v[ch] ? off_d[ch] : 8'($urandom);
  endtask

  task automatic step();
    logic [NUM_CH-1:0] acc;
    int ph;
    int sl;
    int c;
    drive();
    @(posedge clk_32f);
    acc = '0;
    if (!reset) begin
      m_rst  = 1'b1;
      n      = 0;
      m_rr   = 0;
      m_hold = '0;
      cur    = 8'h00;
      e_do   = 1'b0;
      e_bs   = 1'b0;
      e_gv   = 1'b0;
      e_tr   = 1'b0;
      e_gc   = 2'd0;
    end else begin
      m_rst = 1'b0;
      ph    = n % 8;
      sl    = n / 8;
      acc   = in_valid & ~m_hold;
      e_gv  = 1'b0;
      if (ph == 0) begin
        cur = IDLE;
        if (sl >= TRAIN) begin
          for (int k = 0; k < NUM_CH; k++) begin
            c = (m_rr + k) % NUM_CH;
            if (!e_gv && m_hold[c]) begin
              e_gv      = 1'b1;
              e_gc      = 2'(c);
              cur       = m_data[c];
              m_hold[c] = 1'b0;
              m_rr      = (c + 1) % NUM_CH;
            end
          end
        end
      end
      e_bs = (ph == 0);
      e_do = cur[7-ph];
      e_tr = (sl >= TRAIN);
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (acc[ch]) begin
          m_hold[ch] = 1'b1;
          m_data[ch] = in_data[8*ch +: 8];
        end
      end
      n++;
    end
    #1;
    for (int ch = 0; ch < NUM_CH; ch++)
      if (acc[ch]) off_v[ch] = 1'b0;
  endtask

  task automatic test_reset();
    int nbs = 0;
    reset = 1'b0;
    repeat (3) begin
      step();
      vecs++;
      if (got() !== expv()) begin
        errs++;
        $display("FAIL reset_state t=%0t got=%b exp=%b", $time, got(), expv());
      end
    end
    reset = 1'b1;
    repeat (56) begin
      step();
      vecs++;
      if (got() !== expv()) begin
        errs++;
        $display("FAIL idle_train t=%0t got=%b exp=%b", $time, got(), expv());
      end
      if (byte_start) begin
        nbs++;
        if (nbs == 5) begin
          vecs++;
          if (trained !== 1'b1) begin
            errs++;
            $display("FAIL trained_at_5th got=%b exp=1", trained);
          end
        end
      end
    end
  endtask

  task automatic test_train_offer();
    int nbs = 0;
    int bits = -1;
    logic [7:0] sr = 8'h00;
    reset = 1'b0;
    repeat (3) step();
    q[0].push_back(8'hA5);
    reset = 1'b1;
    repeat (48) begin
      step();
      vecs++;
      if (got() !== expv()) begin
        errs++;
        $display("FAIL train_offer t=%0t got=%b exp=%b", $time, got(), expv());
      end
      if (byte_start) begin
        nbs++;
        if (nbs == 5) bits = 0;
      end
      if (bits >= 0 && bits < 8) begin
        sr = {sr[6:0], Data_out};
        bits++;
        if (bits == 8) begin
          vecs++;
          if (sr !== 8'hA5) begin
            errs++;
            $display("FAIL fifth_byte got=%h exp=a5", sr);
          end
        end
      end
    end
  endtask

  task automatic test_round_robin();
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    repeat (40) step();
    q[0].push_back(8'h11);
    q[0].push_back(8'h33);
    q[1].push_back(8'h22);
    repeat (48) begin
      step();
      vecs++;
      if (got() !== expv()) begin
        errs++;
        $display("FAIL round_robin t=%0t got=%b exp=%b", $time, got(), expv());
      end
    end
  endtask

  task automatic test_back_to_back();
    q[1].push_back(8'h5A);
    q[1].push_back(8'hC3);
    q[1].push_back(8'h0F);
    q[1].push_back(8'hF0);
    repeat (48) begin
      step();
      vecs++;
      if (got() !== expv()) begin
        errs++;
        $display("FAIL back_to_back t=%0t got=%b exp=%b", $time, got(), expv());
      end
    end
  endtask

  task automatic test_idle_data();
    q[0].push_back(IDLE);
    repeat (24) begin
      step();
      vecs++;
      if (got() !== expv()) begin
        errs++;
        $display("FAIL idle_data t=%0t got=%b exp=%b", $time, got(), expv());
      end
    end
  endtask

  task automatic test_reset_mid();
    q[0].push_back(8'h96);
    q[0].push_back(8'h69);
    q[1].push_back(8'h3C);
    q[1].push_back(8'hC9);
    repeat (11) step();
    reset = 1'b0;
    repeat (2) begin
      step();
      vecs++;
      if (got() !== expv()) begin
        errs++;
        $display("FAIL mid_reset t=%0t got=%b exp=%b", $time, got(), expv());
      end
    end
    reset = 1'b1;
    repeat (64) begin
      step();
      vecs++;
      if (got() !== expv()) begin
        errs++;
        $display("FAIL retrain t=%0t got=%b exp=%b", $time, got(), expv());
      end
    end
  endtask

  task automatic test_random();
    gate = 1'b1;
    repeat (3000) begin
      reset = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (q[ch].size() < 4 && $urandom_range(0, 7) == 0)
          q[ch].push_back(($urandom_range(0, 9) == 0) ? IDLE : 8'($urandom));
      end
      step();
      vecs++;
      if (got() !== expv()) begin
        errs++;
        $display("FAIL random t=%0t got=%b exp=%b", $time, got(), expv());
      end
    end
    gate = 1'b0;
    reset = 1'b1;
  endtask

  initial begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      m_data[ch] = 8'h00;
      off_d[ch]  = 8'h00;
    end
    test_reset();
    test_train_offer();
    test_round_robin();
    test_back_to_back();
    test_idle_data();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
